// File: rtl/fm_pkg.sv
// Shared types, sizes and the parity helper for the fast-memory AC block.
package fm_pkg;

  localparam int unsigned FM_WORDS_PER_BLOCK = 16;
  localparam int unsigned FM_WORD_WIDTH      = 36;

  // Data word, bit 0 is the MSB.
  typedef logic [0:FM_WORD_WIDTH-1] fm_word_t;
  // Stored cell: data in [0:35], parity bit in [36].
  typedef logic [0:FM_WORD_WIDTH]   fm_cell_t;

  typedef enum logic [1:0] {
    StIdle,
    StIdxWait,
    StIdxRd
  } fm_state_e;

  // Parity bit that makes data plus parity XOR to 1.
  function automatic logic odd_parity(input fm_word_t w);
    return ~(^w);
  endfunction

endpackage

// File: rtl/fm_ac_if.sv
// Handshake/bus bundle between the shift matrix / microcode and the AC block.
interface fm_ac_if #(
  parameter int unsigned NBLOCKS = 8
);
  import fm_pkg::*;

  localparam int unsigned BlkW = $clog2(NBLOCKS);

  logic [3:0]      XR;
  logic            indexed;
  logic            eaStart;
  logic [BlkW-1:0] curBlock;
  logic            fmRead;
  logic [3:0]      fmReadAdr;
  logic            fmWrite;
  logic [3:0]      fmWriteAdr;
  fm_word_t        fmWriteData;
  logic            fmWriteBadParity;
  logic            parityClear;
  fm_word_t        FM;
  logic            fmValid;
  fm_word_t        indexValue;
  logic            indexReady;
  logic            eaBusy;
  logic            fmParityError;

  modport master (
    output XR, indexed, eaStart, curBlock, fmRead, fmReadAdr, fmWrite, fmWriteAdr,
           fmWriteData, fmWriteBadParity, parityClear,
    input  FM, fmValid, indexValue, indexReady, eaBusy, fmParityError
  );

  modport slave (
    input  XR, indexed, eaStart, curBlock, fmRead, fmReadAdr, fmWrite, fmWriteAdr,
           fmWriteData, fmWriteBadParity, parityClear,
    output FM, fmValid, indexValue, indexReady, eaBusy, fmParityError
  );

endinterface

// File: rtl/fm_array.sv
// Synchronous-read AC storage: one write port, one read port, write-to-read bypass.
module fm_array
  import fm_pkg::*;
#(
  parameter int unsigned Depth = 128,
  parameter int unsigned AddrW = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  fm_cell_t         wcell,
  input  logic [AddrW-1:0] raddr,
  output fm_cell_t         rcell
);

  fm_cell_t mem [Depth];
  fm_cell_t rcell_q;

  // Write and registered read; a same-cycle write to the read address wins.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wcell;
    end
    rcell_q <= (we && (waddr == raddr)) ? wcell : mem[raddr];
  end

  assign rcell = rcell_q;

endmodule

// File: rtl/fm_ac.sv
// Fast-memory AC block: microcode read/write port, index-register fetch FSM, parity check.
module fm_ac
  import fm_pkg::*;
#(
  parameter int unsigned NBLOCKS = 8
) (
  input logic    clk,
  input logic    reset_n,
  fm_ac_if.slave bus
);

  localparam int unsigned BlkW  = $clog2(NBLOCKS);
  localparam int unsigned AddrW = BlkW + 4;
  localparam int unsigned Depth = NBLOCKS * FM_WORDS_PER_BLOCK;

  typedef logic [AddrW-1:0] addr_t;

  fm_state_e        state_q, state_d;
  addr_t            idx_adr_q, idx_adr_d;
  logic [Depth-1:0] written_q, written_d;
  logic             fm_rd_q, fm_rd_d;
  logic             noidx_q, noidx_d;
  logic             rd_written_q, rd_written_d;
  logic             perr_q, perr_d;

  addr_t    raddr, waddr;
  fm_cell_t wcell, rcell;
  fm_word_t rd_word;
  logic     rd_active, parity_fail;
  logic     ea_busy, index_ready;

  assign waddr = {bus.curBlock, bus.fmWriteAdr};
  assign wcell = {bus.fmWriteData, odd_parity(bus.fmWriteData) ^ bus.fmWriteBadParity};

  // Microcode read owns the port; otherwise it serves the (pending or new) index fetch.
  always_comb begin
    raddr = idx_adr_q;
    if (bus.fmRead) begin
      raddr = {bus.curBlock, bus.fmReadAdr};
    end else if (state_q == StIdle) begin
      raddr = {bus.curBlock, bus.XR};
    end
  end

  fm_array #(
    .Depth(Depth),
    .AddrW(AddrW)
  ) u_array (
    .clk  (clk),
    .we   (bus.fmWrite),
    .waddr(waddr),
    .wcell(wcell),
    .raddr(raddr),
    .rcell(rcell)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      idx_adr_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_adr_q <= idx_adr_d;
    end
  end

  // FSM next state: latch the index address on an accepted indexed eaStart.
  always_comb begin
    state_d   = state_q;
    idx_adr_d = idx_adr_q;
    unique case (state_q)
      StIdle: begin
        if (bus.eaStart && bus.indexed) begin
          idx_adr_d = {bus.curBlock, bus.XR};
          state_d   = bus.fmRead ? StIdxWait : StIdxRd;
        end
      end
      StIdxWait: begin
        if (!bus.fmRead) begin
          state_d = StIdxRd;
        end
      end
      StIdxRd: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    ea_busy     = 1'b0;
    index_ready = noidx_q;
    unique case (state_q)
      StIdle:    ;
      StIdxWait: ea_busy = 1'b1;
      StIdxRd: begin
        ea_busy     = 1'b1;
        index_ready = 1'b1;
      end
      default:   ;
    endcase
  end

  // Per-cycle read bookkeeping; a same-cycle write counts as written for the bypassed read.
  always_comb begin
    written_d = written_q;
    if (bus.fmWrite) begin
      written_d[waddr] = 1'b1;
    end
    fm_rd_d      = bus.fmRead;
    noidx_d      = (state_q == StIdle) && bus.eaStart && !bus.indexed;
    rd_written_d = written_q[raddr] || (bus.fmWrite && (waddr == raddr));
    perr_d       = (perr_q && !bus.parityClear) || parity_fail;
  end

  // Datapath and status registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      written_q    <= '0;
      fm_rd_q      <= 1'b0;
      noidx_q      <= 1'b0;
      rd_written_q <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      written_q    <= written_d;
      fm_rd_q      <= fm_rd_d;
      noidx_q      <= noidx_d;
      rd_written_q <= rd_written_d;
      perr_q       <= perr_d;
    end
  end

  // Unwritten words read as zero and are never parity checked.
  assign rd_active   = fm_rd_q || (state_q == StIdxRd);
  assign parity_fail = rd_active && rd_written_q && !(^rcell);
  assign rd_word     = rd_written_q ? rcell[0:FM_WORD_WIDTH-1] : '0;

  assign bus.FM            = fm_rd_q ? rd_word : '0;
  assign bus.fmValid       = fm_rd_q;
  assign bus.indexValue    = (state_q == StIdxRd) ? rd_word : '0;
  assign bus.indexReady    = index_ready;
  assign bus.eaBusy        = ea_busy;
  assign bus.fmParityError = perr_q;

endmodule

// File: tb/tb_fm_ac.sv
// Directed bench for fm_ac with a behavioural reference model and per-cycle compare.
module tb_fm_ac;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fm_ac_if #(.NBLOCKS(8)) bus ();

  fm_ac #(.NBLOCKS(8)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0o expected %0o at %0t", name, act, exp, $time);
  endtask

  // Reference model: memory contents, written and corrupted-parity flags per word.
  logic [0:35] m_data [128];
  bit          m_wr   [128];
  bit          m_bad  [128];
  logic [0:35] e_fm, e_idx;
  bit          e_fmv, e_rdy, e_busy, e_perr;
  bit          m_pend, m_err_next;
  int          m_pend_adr;

  function automatic void model_read(input int a, output logic [0:35] v, output bit er);
    int wa;
    wa = int'(bus.curBlock) * 16 + int'(bus.fmWriteAdr);
    if (bus.fmWrite && wa == a) begin
      v  = bus.fmWriteData;
      er = bus.fmWriteBadParity;
    end else if (m_wr[a]) begin
      v  = m_data[a];
      er = m_bad[a];
    end else begin
      v  = '0;
      er = 1'b0;
    end
  endfunction

  always @(posedge clk) begin
    logic [0:35] v;
    bit er, err_now;
    int wa;
    if (!reset_n) begin
      e_fm = '0; e_idx = '0; e_fmv = 0; e_rdy = 0; e_busy = 0; e_perr = 0;
      m_pend = 0; m_err_next = 0;
      for (int i = 0; i < 128; i++) m_wr[i] = 0;
    end else begin
      err_now = 0;
      // Error found on data returned last cycle shows up now; set beats clear.
      e_perr = (e_perr && !bus.parityClear) || m_err_next;
      e_fmv = bus.fmRead; e_fm = '0; e_rdy = 0; e_idx = '0;
      if (bus.fmRead) begin
        model_read(int'(bus.curBlock) * 16 + int'(bus.fmReadAdr), v, er);
        e_fm = v; err_now |= er;
      end
      if (m_pend) begin
        if (!bus.fmRead) begin
          model_read(m_pend_adr, v, er);
          e_idx = v; e_rdy = 1; err_now |= er; m_pend = 0;
        end
      end else if (e_busy) begin
        e_busy = 0;
      end else if (bus.eaStart) begin
        if (!bus.indexed) begin
          e_rdy = 1;
        end else begin
          e_busy = 1; m_pend = 1;
          m_pend_adr = int'(bus.curBlock) * 16 + int'(bus.XR);
          if (!bus.fmRead) begin
            model_read(m_pend_adr, v, er);
            e_idx = v; e_rdy = 1; err_now |= er; m_pend = 0;
          end
        end
      end
      m_err_next = err_now;
      if (bus.fmWrite) begin
        wa = int'(bus.curBlock) * 16 + int'(bus.fmWriteAdr);
        m_data[wa] = bus.fmWriteData; m_wr[wa] = 1; m_bad[wa] = bus.fmWriteBadParity;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (checking) begin
      chk("FM", bus.FM, e_fm);
      chk("fmValid", 36'(bus.fmValid), 36'(e_fmv));
      chk("indexValue", bus.indexValue, e_idx);
      chk("indexReady", 36'(bus.indexReady), 36'(e_rdy));
      chk("eaBusy", 36'(bus.eaBusy), 36'(e_busy));
      chk("fmParityError", 36'(bus.fmParityError), 36'(e_perr));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  localparam logic [35:0] DataA = 36'o123456_701234;
  localparam logic [35:0] DataB = 36'o777000_111222;
  localparam logic [35:0] DataC = 36'o525252_525252;

  initial begin
    reset_n = 1'b0;
    bus.XR = '0; bus.indexed = 0; bus.eaStart = 0; bus.curBlock = '0;
    bus.fmRead = 0; bus.fmReadAdr = '0; bus.fmWrite = 0; bus.fmWriteAdr = '0;
    bus.fmWriteData = '0; bus.fmWriteBadParity = 0; bus.parityClear = 0;
    cyc();
    checking = 1'b1;
    cyc();
    reset_n = 1'b1;
    chk("reset FM", bus.FM, 36'd0);
    chk("reset indexReady", 36'(bus.indexReady), 36'd0);
    chk("reset eaBusy", 36'(bus.eaBusy), 36'd0);

    // Unwritten AC5 block 0 reads as zero.
    bus.fmRead = 1; bus.fmReadAdr = 4'd5;
    cyc();
    bus.fmRead = 0;
    chk("unwritten read FM", bus.FM, 36'd0);
    chk("unwritten read fmValid", 36'(bus.fmValid), 36'd1);
    cyc();
    chk("unwritten read no perr", 36'(bus.fmParityError), 36'd0);

    // Uncontended index fetch of AC3 block 2.
    bus.curBlock = 3'd2; bus.fmWrite = 1; bus.fmWriteAdr = 4'd3; bus.fmWriteData = DataA;
    cyc();
    bus.fmWrite = 0;
    bus.eaStart = 1; bus.indexed = 1; bus.XR = 4'd3;
    cyc();
    bus.eaStart = 0;
    chk("idx indexReady", 36'(bus.indexReady), 36'd1);
    chk("idx indexValue", bus.indexValue, DataA);
    chk("idx eaBusy", 36'(bus.eaBusy), 36'd1);
    cyc();
    chk("idx eaBusy drop", 36'(bus.eaBusy), 36'd0);

    // Contended fetch: fmRead held for three cycles starting with eaStart.
    bus.fmWrite = 1; bus.fmWriteAdr = 4'd4; bus.fmWriteData = DataB;
    cyc();
    bus.fmWrite = 0;
    bus.eaStart = 1; bus.indexed = 1; bus.XR = 4'd3; bus.fmRead = 1; bus.fmReadAdr = 4'd4;
    cyc();
    bus.eaStart = 1; bus.indexed = 0;  // ignored while busy
    chk("wait FM", bus.FM, DataB);
    chk("wait eaBusy", 36'(bus.eaBusy), 36'd1);
    cyc();
    bus.eaStart = 0;
    chk("wait indexReady", 36'(bus.indexReady), 36'd0);
    cyc();
    bus.fmRead = 0;
    chk("wait3 fmValid", 36'(bus.fmValid), 36'd1);
    cyc();
    chk("wait done indexReady", 36'(bus.indexReady), 36'd1);
    chk("wait done indexValue", bus.indexValue, DataA);
    cyc();
    chk("wait done eaBusy", 36'(bus.eaBusy), 36'd0);

    // Non-indexed eaStart.
    bus.eaStart = 1; bus.indexed = 0;
    cyc();
    bus.eaStart = 0;
    chk("noidx indexReady", 36'(bus.indexReady), 36'd1);
    chk("noidx indexValue", bus.indexValue, 36'd0);
    chk("noidx eaBusy", 36'(bus.eaBusy), 36'd0);

    // Forced bad parity on AC7 block 0, sticky flag, then clear.
    bus.curBlock = 3'd0; bus.fmWrite = 1; bus.fmWriteAdr = 4'd7; bus.fmWriteData = 36'o1;
    bus.fmWriteBadParity = 1;
    cyc();
    bus.fmWrite = 0; bus.fmWriteBadParity = 0; bus.fmRead = 1; bus.fmReadAdr = 4'd7;
    cyc();
    bus.fmRead = 0;
    chk("bad read FM", bus.FM, 36'o1);
    cyc();
    chk("perr set", 36'(bus.fmParityError), 36'd1);
    cyc();
    chk("perr sticky", 36'(bus.fmParityError), 36'd1);
    bus.parityClear = 1;
    cyc();
    bus.parityClear = 0;
    chk("perr cleared", 36'(bus.fmParityError), 36'd0);

    // Same-cycle write/read of AC7 returns write data.
    bus.fmWrite = 1; bus.fmWriteAdr = 4'd7; bus.fmWriteData = DataC; bus.fmRead = 1;
    cyc();
    bus.fmWrite = 0; bus.fmRead = 0;
    chk("bypass FM", bus.FM, DataC);
    cyc();
    chk("bypass good parity", 36'(bus.fmParityError), 36'd0);

    // Bypassed bad-parity write, clear arriving in the detection cycle: set wins.
    bus.fmWrite = 1; bus.fmWriteAdr = 4'd6; bus.fmWriteData = DataB; bus.fmWriteBadParity = 1;
    bus.fmRead = 1; bus.fmReadAdr = 4'd6;
    cyc();
    bus.fmWrite = 0; bus.fmWriteBadParity = 0; bus.fmRead = 0; bus.parityClear = 1;
    cyc();
    bus.parityClear = 0;
    chk("set wins over clear", 36'(bus.fmParityError), 36'd1);
    bus.parityClear = 1;
    cyc();
    bus.parityClear = 0;

    // Reset while in the index-read state.
    bus.curBlock = 3'd2; bus.eaStart = 1; bus.indexed = 1; bus.XR = 4'd3;
    cyc();
    bus.eaStart = 0;
    reset_n = 0;
    cyc();
    reset_n = 1;
    chk("rst idxrd indexReady", 36'(bus.indexReady), 36'd0);
    chk("rst idxrd indexValue", bus.indexValue, 36'd0);
    chk("rst idxrd eaBusy", 36'(bus.eaBusy), 36'd0);

    // Reset while waiting on fmRead: fetch is abandoned, no pulse afterwards.
    bus.eaStart = 1; bus.indexed = 1; bus.fmRead = 1; bus.fmReadAdr = 4'd3;
    cyc();
    bus.eaStart = 0; bus.fmRead = 0; reset_n = 0;
    cyc();
    reset_n = 1;
    cyc();
    chk("rst wait no ready", 36'(bus.indexReady), 36'd0);
    chk("rst wait idle", 36'(bus.eaBusy), 36'd0);

    // Written flags cleared by reset: AC3 block 2 reads as zero again.
    bus.fmRead = 1; bus.fmReadAdr = 4'd3;
    cyc();
    bus.fmRead = 0;
    chk("post reset read FM", bus.FM, 36'd0);
    cyc();
    cyc();

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
